// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencing controller.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN,
        ST_QUIESCE,
        ST_DRAIN
    } rs_state_e;

    // One counter serves every timed state, so size it for the longest interval.
    function automatic int cnt_width(input int hold, input int gap, input int tmo);
        int m;
        m = hold;
        if (gap > m) m = gap;
        if (tmo > m) m = tmo;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset deassertion synchroniser: asserts asynchronously, releases on clk.
module reset_sync #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    output logic srst_n
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[STAGES-2:0], 1'b1};
    end

    assign srst_n = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Multi-domain reset sequencer: ordered domain release plus quiesced warm reset.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS     = 4,
    parameter int SYNC_STAGES     = 3,
    parameter int HOLD_CYCLES     = 16,
    parameter int GAP_CYCLES      = 4,
    parameter int QUIESCE_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sw_rst_req,
    output logic                   sw_rst_ack,
    input  logic [NUM_DOMAINS-1:0] dom_idle,
    output logic [NUM_DOMAINS-1:0] quiesce_req,
    output logic [NUM_DOMAINS-1:0] dom_rst_n,
    output logic                   all_released,
    output logic                   timeout_err
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES, QUIESCE_TIMEOUT);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(QUIESCE_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    rs_state_e               state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [NUM_DOMAINS-1:0]  dom_nxt, quiesce_nxt;
    logic                    ack_nxt, rel_nxt, terr_nxt;
    logic                    warm, warm_nxt;
    logic                    srst_n;

    reset_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .srst_n (srst_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RESET;
            cnt          <= '0;
            idx          <= '0;
            warm         <= 1'b0;
            dom_rst_n    <= '0;
            quiesce_req  <= '0;
            sw_rst_ack   <= 1'b0;
            all_released <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            idx          <= idx_nxt;
            warm         <= warm_nxt;
            dom_rst_n    <= dom_nxt;
            quiesce_req  <= quiesce_nxt;
            sw_rst_ack   <= ack_nxt;
            all_released <= rel_nxt;
            timeout_err  <= terr_nxt;
        end
    end

    // Next-state and next-output values; every output is registered from these.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = '0;
        idx_nxt     = idx;
        warm_nxt    = warm;
        dom_nxt     = dom_rst_n;
        quiesce_nxt = '0;
        ack_nxt     = 1'b0;
        terr_nxt    = timeout_err;
        unique case (state)
            ST_RESET: begin
                dom_nxt = '0;
                if (srst_n) state_nxt = ST_HOLD;
            end
            ST_HOLD, ST_DRAIN: begin
                dom_nxt = '0;
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == HOLD_LAST) begin
                    state_nxt  = ST_RELEASE;
                    cnt_nxt    = '0;
                    idx_nxt    = '0;
                    dom_nxt[0] = 1'b1;
                end
            end
            ST_RELEASE: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (idx == IDX_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                    ack_nxt   = warm;
                    warm_nxt  = 1'b0;
                end else if (cnt == GAP_LAST) begin
                    cnt_nxt          = '0;
                    idx_nxt          = idx + IDX_W'(1);
                    dom_nxt[idx_nxt] = 1'b1;
                end
            end
            ST_RUN: begin
                if (sw_rst_req) begin
                    state_nxt   = ST_QUIESCE;
                    quiesce_nxt = '1;
                end
            end
            ST_QUIESCE: begin
                quiesce_nxt = '1;
                cnt_nxt     = cnt + CNT_W'(1);
                // Idle takes priority over a timeout landing on the same edge.
                if ((&dom_idle) || (cnt == TMO_LAST)) begin
                    state_nxt   = ST_DRAIN;
                    cnt_nxt     = '0;
                    quiesce_nxt = '0;
                    dom_nxt     = '0;
                    warm_nxt    = 1'b1;
                    if (!(&dom_idle)) terr_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_RESET;
        endcase
        rel_nxt = (state_nxt == ST_RUN) && (&dom_nxt);
    end

endmodule
